reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file: successor to the single-write, two-read 32x32 file.
- Supports NREAD registered read ports, two write ports with fixed priority, and write-to-read bypass.
- Keeps a per-register busy scoreboard for the decode/issue stage.
- Sits between decode (read and issue requests) and writeback (two retire lanes) in the pipelined core.

Parameters:
- DWIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, >= 2.
- NREAD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 is hard-wired to zero and never busy; when 0 it is a normal register.
- AW (localparam), $clog2(DEPTH), register ID width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- re  in  1  read enable; when 0, all read outputs hold their value.
- rs_id  in  NREAD*AW  read IDs; port k uses bits [k*AW +: AW].
- rs_data  out  NREAD*DWIDTH  registered read data, port k at [k*DWIDTH +: DWIDTH].
- rs_busy  out  NREAD  registered busy flag of the register read on port k.
- we0  in  1  write enable, lane 0.
- wd_id0  in  AW  destination ID, lane 0.
- wd0  in  DWIDTH  write data, lane 0.
- we1  in  1  write enable, lane 1 (higher priority).
- wd_id1  in  AW  destination ID, lane 1.
- wd1  in  DWIDTH  write data, lane 1.
- iss_v  in  1  issue valid; marks iss_id busy.
- iss_id  in  AW  destination ID of the newly issued instruction.
- busy_vec  out  DEPTH  current scoreboard state; bit i = register i busy.

Behaviour:
- Reset, synchronous on rising clk with rst=1:
  - All registers are cleared to 0.
  - rs_data and rs_busy are cleared to 0.
  - busy_vec is cleared to 0.
  - All writes, reads and issues in that cycle are ignored.
  - Reset asserted mid-operation overrides everything in that cycle.
- Write:
  - On rising clk, if weN=1, R[wd_idN] <= wdN.
  - Register 0 is decided by ID, never by data value. If ZERO_REG=1, a write to ID 0 is discarded and R[0] stays 0.
  - Both lanes writing the same ID in the same cycle: lane 1's data wins.
- Read:
  - Latency is 1 cycle. When re=1, rs_data[k] <= value of R[rs_id[k]] as it is after this edge's writes (bypass).
    - If we1 and wd_id1==rs_id[k], return wd1.
    - Else if we0 and wd_id0==rs_id[k], return wd0.
    - Else return the stored value.
  - Bypass never applies to ID 0 when ZERO_REG=1; that read returns 0.
  - When re=0, rs_data and rs_busy hold their previous values.
- Scoreboard:
  - busy[i] is set on iss_v && iss_id==i.
  - busy[i] is cleared on (we0 && wd_id0==i) || (we1 && wd_id1==i).
  - Set and clear of the same ID in one cycle: set wins, because the new producer is outstanding.
  - If ZERO_REG=1, busy[0] is constant 0.
  - rs_busy[k] samples the post-edge busy value of rs_id[k], same bypass rule as data: a same-cycle clear gives 0, a same-cycle issue gives 1.
  - busy_vec is the registered scoreboard state itself, with no extra latency beyond the register.
- Out-of-range IDs cannot occur (DEPTH is a power of two).
- No combinational path from any input to any output.

Decomposition:
- Shared package rf_pkg:
  - Default DWIDTH/DEPTH constants.
  - Register ID typedef.
  - ZERO_REG default.
- One natural sub-module, rf_scoreboard: busy-bit array with set/clear priority logic and busy_vec.
- The read-port bypass mux is instantiated NREAD times via generate.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then re=1, rs_id={5,0} -> next cycle rs_data all 0, rs_busy 0, busy_vec 0.
- Write then read:
  - we0=1, wd_id0=3, wd0=0xDEADBEEF.
  - Next cycle rs_id[0]=3 -> rs_data[0]=0xDEADBEEF one cycle later.
  - Write ID 0 with 0x1234 and read ID 0 -> 0.
- Dual-write collision and bypass:
  - Same cycle: we0 and we1 both to ID 7, wd0=0x11, wd1=0x22, rs_id[1]=7, re=1.
  - Next cycle rs_data[1]=0x22; a later read of 7 also gives 0x22.
- Scoreboard:
  - iss_v, iss_id=9 -> busy_vec[9]=1.
  - Writeback we1 to ID 9 -> busy_vec[9]=0.
  - Same cycle iss_id=9 and we0 to ID 9 -> busy_vec[9] stays 1.
- Read hold: re=1 read ID 3 (0xDEADBEEF), then re=0 while writing 0x5 to ID 3 -> rs_data[0] stays 0xDEADBEEF until re=1.
- Reset mid-operation: with busy_vec[9]=1 and R[3]!=0, assert rst with we0=1 to ID 3 -> all registers 0, busy_vec 0, the write is discarded.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   RF_DWIDTH   default register width
//   RF_DEPTH    default register count (power of two)
//   RF_ZERO_REG default for the hard-wired-zero register 0
//   rf_id_t     register ID type for the default depth
package rf_pkg;
    localparam int RF_DWIDTH   = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = 1;
    localparam int RF_AW       = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0] rf_id_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst         clock, synchronous active-high reset
//   iss_v, iss_id    issue: marks iss_id busy
//   we0/wd_id0,
//   we1/wd_id1       writeback lanes: clear busy of the written ID
//   busy_next        next-state scoreboard (feeds the read-port bypass)
//   busy_vec         registered scoreboard state
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = RF_ZERO_REG,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_id,
    input  logic             we0,
    input  logic [AW-1:0]    wd_id0,
    input  logic             we1,
    input  logic [AW-1:0]    wd_id1,
    output logic [DEPTH-1:0] busy_next,
    output logic [DEPTH-1:0] busy_vec
);
    logic [DEPTH-1:0] set_dec;
    logic [DEPTH-1:0] clr_dec;

    always_comb begin
        set_dec = iss_v ? (DEPTH'(1) << iss_id) : '0;
        clr_dec = (we0 ? (DEPTH'(1) << wd_id0) : '0)
                | (we1 ? (DEPTH'(1) << wd_id1) : '0);
        // Set is applied after clear: a freshly issued producer stays
        // outstanding even if an older one retires to the same ID now.
        busy_next = (busy_vec & ~clr_dec) | set_dec;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_next;
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NREAD registered read ports with
// write-to-read bypass, two prioritised write lanes (lane 1 wins),
// and a busy scoreboard for issue.
//   clk, rst            clock, synchronous active-high reset
//   re                  read enable; outputs hold when low
//   rs_id               read IDs, port k at [k*AW +: AW]
//   rs_data, rs_busy    registered read data / busy flag per port
//   we0/wd_id0/wd0      write lane 0
//   we1/wd_id1/wd1      write lane 1 (higher priority)
//   iss_v, iss_id       issue request, marks iss_id busy
//   busy_vec            scoreboard state
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DWIDTH   = RF_DWIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = RF_ZERO_REG,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re,
    input  logic [NREAD*AW-1:0]     rs_id,
    output logic [NREAD*DWIDTH-1:0] rs_data,
    output logic [NREAD-1:0]        rs_busy,
    input  logic                    we0,
    input  logic [AW-1:0]           wd_id0,
    input  logic [DWIDTH-1:0]       wd0,
    input  logic                    we1,
    input  logic [AW-1:0]           wd_id1,
    input  logic [DWIDTH-1:0]       wd1,
    input  logic                    iss_v,
    input  logic [AW-1:0]           iss_id,
    output logic [DEPTH-1:0]        busy_vec
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_next;

    // Writes to ID 0 are dropped by ID when register 0 is hard-wired.
    logic wr0_ok, wr1_ok;
    assign wr0_ok = we0 && !((ZERO_REG != 0) && (wd_id0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (wd_id1 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr0_ok) mem[wd_id0] <= wd0;
            // Lane 1 is assigned last so it wins an ID collision.
            if (wr1_ok) mem[wd_id1] <= wd1;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_v     (iss_v),
        .iss_id    (iss_id),
        .we0       (we0),
        .wd_id0    (wd_id0),
        .we1       (we1),
        .wd_id1    (wd_id1),
        .busy_next (busy_next),
        .busy_vec  (busy_vec)
    );

    // Per-port bypass mux: each port sees the register as it will be
    // after this edge's writes.
    logic [DWIDTH-1:0] rd_nxt [NREAD];
    logic              rb_nxt [NREAD];

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] id;
        logic          zero_id;
        assign id      = rs_id[k*AW +: AW];
        assign zero_id = (ZERO_REG != 0) && (id == '0);

        always_comb begin
            if (zero_id)                   rd_nxt[k] = '0;
            else if (we1 && wd_id1 == id)  rd_nxt[k] = wd1;
            else if (we0 && wd_id0 == id)  rd_nxt[k] = wd0;
            else                           rd_nxt[k] = mem[id];
        end
        assign rb_nxt[k] = busy_next[id];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_data <= '0;
            rs_busy <= '0;
        end else if (re) begin
            for (int k = 0; k < NREAD; k++) begin
                rs_data[k*DWIDTH +: DWIDTH] <= rd_nxt[k];
                rs_busy[k]                  <= rb_nxt[k];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int DP = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst, re, we0, we1, iss_v;
    logic [NR*AW-1:0]  rs_id;
    logic [NR*DW-1:0]  rs_data;
    logic [NR-1:0]     rs_busy;
    logic [AW-1:0]     wd_id0, wd_id1, iss_id;
    logic [DW-1:0]     wd0, wd1;
    logic [DP-1:0]     busy_vec;

    reg_file_mp #(.DWIDTH(DW), .DEPTH(DP), .NREAD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .re(re), .rs_id(rs_id), .rs_data(rs_data),
        .rs_busy(rs_busy), .we0(we0), .wd_id0(wd_id0), .wd0(wd0),
        .we1(we1), .wd_id1(wd_id1), .wd1(wd1), .iss_v(iss_v),
        .iss_id(iss_id), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers and busy flags.
    logic [DW-1:0] m_r    [DP];
    logic          m_busy [DP];
    logic [DW-1:0] m_data [NR];
    logic          m_rb   [NR];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < DP; i++) begin m_r[i] = '0; m_busy[i] = 1'b0; end
            for (int k = 0; k < NR; k++) begin m_data[k] = '0; m_rb[k] = 1'b0; end
            return;
        end
        // Architectural order: lane 0 writes, then lane 1 overwrites.
        if (we0 && wd_id0 != 0) m_r[wd_id0] = wd0;
        if (we1 && wd_id1 != 0) m_r[wd_id1] = wd1;
        // Retire first, then a new issue re-marks the register.
        if (we0) m_busy[wd_id0] = 1'b0;
        if (we1) m_busy[wd_id1] = 1'b0;
        if (iss_v) m_busy[iss_id] = 1'b1;
        m_busy[0] = 1'b0;
        if (re) begin
            for (int k = 0; k < NR; k++) begin
                m_data[k] = m_r[rs_id[k*AW +: AW]];
                m_rb[k]   = m_busy[rs_id[k*AW +: AW]];
            end
        end
    endtask

    task automatic check(input string tag);
        logic [NR*DW-1:0] e_data;
        logic [NR-1:0]    e_rb;
        logic [DP-1:0]    e_bv;
        for (int k = 0; k < NR; k++) begin
            e_data[k*DW +: DW] = m_data[k];
            e_rb[k]            = m_rb[k];
        end
        for (int i = 0; i < DP; i++) e_bv[i] = m_busy[i];
        n_cmp += 3;
        assert (rs_data === e_data) else begin
            n_bad++;
            $error("FAIL %s rs_data got %h exp %h", tag, rs_data, e_data);
        end
        assert (rs_busy === e_rb) else begin
            n_bad++;
            $error("FAIL %s rs_busy got %b exp %b", tag, rs_busy, e_rb);
        end
        assert (busy_vec === e_bv) else begin
            n_bad++;
            $error("FAIL %s busy_vec got %h exp %h", tag, busy_vec, e_bv);
        end
    endtask

    // One clock: model the edge, clock the DUT, compare, return to idle.
    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag);
        rst = 0; we0 = 0; we1 = 0; iss_v = 0;
    endtask

    task automatic rd(input int p0, input int p1);
        rs_id[0*AW +: AW] = AW'(p0);
        rs_id[1*AW +: AW] = AW'(p1);
    endtask

    initial begin
        rst = 1; re = 0; we0 = 0; we1 = 0; iss_v = 0;
        rs_id = '0; wd_id0 = '0; wd_id1 = '0; iss_id = '0; wd0 = '0; wd1 = '0;
        for (int i = 0; i < DP; i++) begin m_r[i] = '0; m_busy[i] = 1'b0; end
        for (int k = 0; k < NR; k++) begin m_data[k] = '0; m_rb[k] = 1'b0; end
        #1;

        // Reset, then read {5,0}
        re = 1; rd(0, 5);
        rst = 1; cyc("reset0");
        rst = 1; cyc("reset1");
        cyc("read_after_reset");

        // Write then read
        we0 = 1; wd_id0 = 3; wd0 = 32'hDEADBEEF; re = 0;
        cyc("write3");
        re = 1; rd(3, 0);
        cyc("read3");
        we0 = 1; wd_id0 = 0; wd0 = 32'h1234; rd(0, 0);
        cyc("write0_bypass");
        cyc("read0");

        // Dual-write collision with bypass on port 1
        we0 = 1; wd_id0 = 7; wd0 = 32'h11;
        we1 = 1; wd_id1 = 7; wd1 = 32'h22; rd(3, 7);
        cyc("collide7");
        rd(7, 3);
        cyc("read7");

        // Scoreboard
        iss_v = 1; iss_id = 9; rd(9, 3);
        cyc("issue9");
        we1 = 1; wd_id1 = 9; wd1 = 32'h99;
        cyc("retire9");
        iss_v = 1; iss_id = 9; we0 = 1; wd_id0 = 9; wd0 = 32'h98;
        cyc("issue_retire9");
        iss_v = 1; iss_id = 0;
        cyc("issue0");

        // Read hold
        rd(3, 9);
        cyc("read3_again");
        re = 0; we0 = 1; wd_id0 = 3; wd0 = 32'h5;
        cyc("hold");
        cyc("hold2");
        re = 1;
        cyc("unhold");

        // Reset mid-operation with a write pending
        rst = 1; we0 = 1; wd_id0 = 3; wd0 = 32'hCAFE;
        cyc("mid_reset");
        rd(3, 9);
        cyc("after_mid_reset");

        // Randomized traffic; small ID range forces collisions
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            re     = ($urandom_range(0, 3) != 0);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            iss_v  = $urandom_range(0, 1);
            wd_id0 = AW'($urandom_range(0, 7));
            wd_id1 = AW'($urandom_range(0, 7));
            iss_id = AW'($urandom_range(0, 7));
            wd0    = $urandom;
            wd1    = $urandom;
            rd($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                                                : $urandom_range(0, 7));
            cyc("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
